// File: rtl/letc_core_stage_m.sv
// LETC Core memory stage: takes E's output register, runs loads/stores over a valid/ready
// data-memory port with lane alignment and load extension, and registers the result for W.

package letc_core_pkg;
    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [1:0]  rd_src;
        logic [4:0]  rd_idx;
        logic        rd_we;
        logic [1:0]  csr_alu_op;
        logic [11:0] csr_idx;
        logic [31:0] old_csr_value;
        logic [31:0] new_csr_value;
        logic [31:0] alu_result;
        logic [31:0] rs2_rdata;
        logic [1:0]  memory_op;
        logic        memory_signed;
        logic [1:0]  memory_size;
    } e_to_m_s;

    typedef struct packed {
        logic        valid;
        logic [1:0]  rd_src;
        logic [4:0]  rd_idx;
        logic        rd_we;
        logic [1:0]  csr_alu_op;
        logic [11:0] csr_idx;
        logic [31:0] old_csr_value;
        logic [31:0] new_csr_value;
        logic [31:0] alu_result;
        logic [31:0] memory_rdata;
    } m_to_w_s;
endpackage

module letc_core_stage_m
    import letc_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  e_to_m_s     e_to_m,
    input  logic        m_flush,
    output logic        m_ready,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        m_misaligned,
    output m_to_w_s     m_to_w
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_data_f(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] data;
        case (size)
            SIZE_BYTE: data = {4{rs2[7:0]}};
            SIZE_HALF: data = {2{rs2[15:0]}};
            SIZE_WORD: data = rs2;
            default:   data = 32'h0000_0000;
        endcase
        return data;
    endfunction

    function automatic logic [3:0] store_strb_f(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << off;
            SIZE_HALF: strb = 4'b0011 << off;
            SIZE_WORD: strb = 4'b1111;
            default:   strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] load_format_f(input logic [1:0]  size,
                                                  input logic        sgn,
                                                  input logic [1:0]  off,
                                                  input logic [31:0] rdata);
        logic [31:0] s;
        logic [31:0] res;
        s = rdata >> {off, 3'b000};
        case (size)
            SIZE_BYTE: res = {{24{sgn & s[7]}}, s[7:0]};
            SIZE_HALF: res = {{16{sgn & s[15]}}, s[15:0]};
            SIZE_WORD: res = s;
            default:   res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic m_to_w_s pass_f(input e_to_m_s e, input logic [31:0] rdata, input logic vld);
        m_to_w_s w;
        w.valid         = vld;
        w.rd_src        = e.rd_src;
        w.rd_idx        = e.rd_idx;
        w.rd_we         = e.rd_we;
        w.csr_alu_op    = e.csr_alu_op;
        w.csr_idx       = e.csr_idx;
        w.old_csr_value = e.old_csr_value;
        w.new_csr_value = e.new_csr_value;
        w.alu_result    = e.alu_result;
        w.memory_rdata  = rdata;
        return w;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        killed_q, killed_d;
    m_to_w_s     m_to_w_q, m_to_w_d;

    logic [1:0]  off_s;
    logic        is_mem_s;
    logic        is_store_s;
    logic        misaligned_s;
    logic        req_valid_s;
    logic        misaligned_pulse_s;
    logic        m_ready_s;
    logic [31:0] load_data_s;

    assign off_s        = e_to_m.alu_result[1:0];
    assign is_mem_s     = (e_to_m.memory_op != MEM_NOP);
    assign is_store_s   = (e_to_m.memory_op == MEM_STORE);
    assign misaligned_s = misaligned_f(e_to_m.memory_size, off_s);
    assign load_data_s  = load_format_f(e_to_m.memory_size, e_to_m.memory_signed, off_s, dmem_rsp_rdata);

    // Next-state, handshake and W-result computation for the IDLE/REQ/RSP sequencer.
    always_comb begin
        state_d            = state_q;
        killed_d           = killed_q;
        m_to_w_d           = m_to_w_q;
        m_to_w_d.valid     = 1'b0;
        m_ready_s          = 1'b0;
        req_valid_s        = 1'b0;
        misaligned_pulse_s = 1'b0;
        case (state_q)
            IDLE: begin
                m_ready_s = 1'b1;
                killed_d  = 1'b0;
                // A flush here wins over everything: nothing is issued and W sees a bubble.
                if (e_to_m.valid && !m_flush) begin
                    if (!is_mem_s) begin
                        m_to_w_d = pass_f(e_to_m, 32'h0000_0000, 1'b1);
                    end else if (misaligned_s) begin
                        misaligned_pulse_s = 1'b1;
                    end else begin
                        m_ready_s   = 1'b0;
                        req_valid_s = 1'b1;
                        if (dmem_req_ready) begin
                            state_d = RSP;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end else begin
                    m_to_w_d.valid = 1'b0;
                end
            end
            REQ: begin
                req_valid_s = 1'b1;
                if (m_flush) begin
                    killed_d = 1'b1;
                end else begin
                    killed_d = killed_q;
                end
                if (dmem_req_ready) begin
                    state_d = RSP;
                end else begin
                    state_d = REQ;
                end
            end
            RSP: begin
                if (dmem_rsp_valid) begin
                    m_ready_s = 1'b1;
                    if (is_store_s) begin
                        m_to_w_d = pass_f(e_to_m, 32'h0000_0000, !(killed_q || m_flush));
                    end else begin
                        m_to_w_d = pass_f(e_to_m, load_data_s, !(killed_q || m_flush));
                    end
                    killed_d = 1'b0;
                    state_d  = IDLE;
                end else if (m_flush) begin
                    killed_d = 1'b1;
                end else begin
                    killed_d = killed_q;
                end
            end
            default: begin
                state_d  = IDLE;
                killed_d = 1'b0;
            end
        endcase
    end

    // Sequencer state, kill flag and W output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            killed_q <= 1'b0;
            m_to_w_q <= '0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            m_to_w_q <= m_to_w_d;
        end
    end

    // Request/abort strobes are combinational, so hold them low while reset is asserted.
    assign dmem_req_valid = req_valid_s & rst_n;
    assign m_misaligned   = misaligned_pulse_s & rst_n;
    assign m_ready        = m_ready_s;
    assign dmem_req_addr  = {e_to_m.alu_result[31:2], 2'b00};
    assign dmem_req_we    = is_store_s;
    assign dmem_req_wdata = is_store_s ? store_data_f(e_to_m.memory_size, e_to_m.rs2_rdata) : 32'h0000_0000;
    assign dmem_req_wstrb = is_store_s ? store_strb_f(e_to_m.memory_size, off_s) : 4'b0000;
    assign m_to_w         = m_to_w_q;

endmodule

// File: tb/tb_letc_core_stage_m.sv
// Scenario bench for the LETC memory stage: expected W results are queued at issue time
// and popped when the stage presents a valid result.

module tb_letc_core_stage_m;
    import letc_core_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    e_to_m_s     e_to_m;
    logic        m_flush;
    logic        m_ready;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        m_misaligned;
    m_to_w_s     m_to_w;

    exp_t sb[$];
    exp_t e;
    int   n_cmp;
    int   n_err;

    letc_core_stage_m dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .e_to_m         (e_to_m),
        .m_flush        (m_flush),
        .m_ready        (m_ready),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_req_wstrb (dmem_req_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .m_misaligned   (m_misaligned),
        .m_to_w         (m_to_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_instr(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd);
        e_to_m               = '0;
        e_to_m.valid         = 1'b1;
        e_to_m.rd_src        = 2'd1;
        e_to_m.rd_idx        = rd;
        e_to_m.rd_we         = 1'b1;
        e_to_m.alu_result    = addr;
        e_to_m.rs2_rdata     = rs2;
        e_to_m.memory_op     = op;
        e_to_m.memory_size   = size;
        e_to_m.memory_signed = sgn;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_flush = 1'b0;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0000_0000;
        drive_instr(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_0100, 32'h0, 5'd1);
        @(negedge clk);
        n_cmp++; if (m_to_w !== '0) begin n_err++; $display("FAIL reset_m_to_w: got %h want 0", m_to_w); end
        n_cmp++; if (dmem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b want 0", dmem_req_valid); end
        drive_instr(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_0101, 32'h0, 5'd1);
        @(negedge clk);
        n_cmp++; if (m_misaligned !== 1'b0) begin n_err++; $display("FAIL reset_misaligned: got %b want 0", m_misaligned); end
        @(posedge clk); #1;
        e_to_m = '0;
        dmem_req_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL reset_idle_ready: got %b want 1", m_ready); end
    endtask

    task automatic test_alu();
        @(posedge clk); #1;
        drive_instr(MEM_NOP, SIZE_WORD, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
        sb.push_back('{alu: 32'h0000_1234, rdata: 32'h0, rd: 5'd5});
        @(negedge clk);
        n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b want 1", m_ready); end
        n_cmp++; if (dmem_req_valid !== 1'b0) begin n_err++; $display("FAIL alu_no_req: got %b want 0", dmem_req_valid); end
        @(posedge clk); #1;
        e_to_m = '0;
        @(negedge clk);
        n_cmp++;
        if (m_to_w.valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL alu_wb_valid: got %b want 1", m_to_w.valid);
        end else begin
            e = sb.pop_front();
            if (m_to_w.alu_result !== e.alu || m_to_w.memory_rdata !== e.rdata || m_to_w.rd_idx !== e.rd) begin
                n_err++; $display("FAIL alu_wb_data: got %h/%h/%0d want %h/%h/%0d", m_to_w.alu_result,
                                  m_to_w.memory_rdata, m_to_w.rd_idx, e.alu, e.rdata, e.rd);
            end
        end
        @(negedge clk);
        n_cmp++; if (m_to_w.valid !== 1'b0) begin n_err++; $display("FAIL alu_bubble_after: got %b want 0", m_to_w.valid); end
    endtask

    task automatic test_lb();
        int low;
        for (int sgn = 1; sgn >= 0; sgn--) begin
            low = 0;
            @(posedge clk); #1;
            drive_instr(MEM_LOAD, SIZE_BYTE, sgn[0], 32'h0000_0103, 32'h0, 5'd7);
            dmem_req_ready = 1'b1;
            dmem_rsp_rdata = 32'h8055_6677;
            sb.push_back('{alu: 32'h0000_0103, rdata: (sgn != 0) ? 32'hFFFF_FF80 : 32'h0000_0080, rd: 5'd7});
            @(negedge clk);
            n_cmp++;
            if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h0000_0100 || dmem_req_we !== 1'b0 || dmem_req_wstrb !== 4'b0000) begin
                n_err++; $display("FAIL lb_req: got v%b a%h we%b s%b want v1 a00000100 we0 s0000",
                                  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wstrb);
            end
            if (m_ready === 1'b0) low++;
            @(posedge clk); #1;
            dmem_req_ready = 1'b0;
            @(negedge clk);
            n_cmp++; if (dmem_req_valid !== 1'b0) begin n_err++; $display("FAIL lb_req_dropped: got %b want 0", dmem_req_valid); end
            if (m_ready === 1'b0) low++;
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b1;
            @(negedge clk);
            n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL lb_rsp_ready: got %b want 1", m_ready); end
            n_cmp++; if (low !== 2) begin n_err++; $display("FAIL lb_stall_cycles: got %0d want 2", low); end
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b0;
            e_to_m = '0;
            @(negedge clk);
            n_cmp++;
            if (m_to_w.valid !== 1'b1 || sb.size() == 0) begin
                n_err++; $display("FAIL lb_wb_valid: got %b want 1", m_to_w.valid);
            end else begin
                e = sb.pop_front();
                if (m_to_w.memory_rdata !== e.rdata || m_to_w.alu_result !== e.alu || m_to_w.rd_idx !== e.rd) begin
                    n_err++; $display("FAIL lb_wb_data: got %h/%h want %h/%h", m_to_w.memory_rdata, m_to_w.alu_result, e.rdata, e.alu);
                end
            end
        end
    endtask

    task automatic test_sh_backpressure();
        int held;
        held = 0;
        @(posedge clk); #1;
        drive_instr(MEM_STORE, SIZE_HALF, 1'b0, 32'h0000_0202, 32'hABCD_1234, 5'd0);
        dmem_rsp_rdata = 32'h0000_0000;
        sb.push_back('{alu: 32'h0000_0202, rdata: 32'h0, rd: 5'd0});
        for (int i = 0; i < 4; i++) begin
            dmem_req_ready = (i == 3);
            @(negedge clk);
            if (dmem_req_valid === 1'b1) held++;
            n_cmp++;
            if (dmem_req_addr !== 32'h0000_0200 || dmem_req_wdata !== 32'h1234_1234 || dmem_req_wstrb !== 4'b1100 || dmem_req_we !== 1'b1) begin
                n_err++; $display("FAIL sh_payload[%0d]: got a%h d%h s%b we%b want a00000200 d12341234 s1100 we1",
                                  i, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, dmem_req_we);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (held !== 4) begin n_err++; $display("FAIL sh_req_held: got %0d want 4", held); end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_ready !== 1'b1 || dmem_req_valid !== 1'b0) begin n_err++; $display("FAIL sh_ack: got rdy%b v%b want rdy1 v0", m_ready, dmem_req_valid); end
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        e_to_m = '0;
        @(negedge clk);
        n_cmp++;
        if (m_to_w.valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL sh_wb_valid: got %b want 1", m_to_w.valid);
        end else begin
            e = sb.pop_front();
            if (m_to_w.alu_result !== e.alu || m_to_w.memory_rdata !== e.rdata) begin
                n_err++; $display("FAIL sh_wb_data: got %h/%h want %h/%h", m_to_w.alu_result, m_to_w.memory_rdata, e.alu, e.rdata);
            end
        end
    endtask

    task automatic test_formats();
        logic [1:0]  op, size;
        logic        sgn;
        logic [31:0] addr, rs2, rdata, exp_rdata, exp_wdata;
        logic [3:0]  exp_wstrb;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin op = MEM_LOAD;  size = SIZE_HALF; sgn = 1'b1; addr = 32'h302; rs2 = 32'h0;          rdata = 32'h8001_1234; exp_rdata = 32'hFFFF_8001; exp_wdata = 32'h0;          exp_wstrb = 4'b0000; end
                1: begin op = MEM_LOAD;  size = SIZE_HALF; sgn = 1'b0; addr = 32'h300; rs2 = 32'h0;          rdata = 32'hAAAA_F00D; exp_rdata = 32'h0000_F00D; exp_wdata = 32'h0;          exp_wstrb = 4'b0000; end
                2: begin op = MEM_LOAD;  size = SIZE_WORD; sgn = 1'b1; addr = 32'h304; rs2 = 32'h0;          rdata = 32'hDEAD_BEEF; exp_rdata = 32'hDEAD_BEEF; exp_wdata = 32'h0;          exp_wstrb = 4'b0000; end
                3: begin op = MEM_LOAD;  size = SIZE_BYTE; sgn = 1'b1; addr = 32'h305; rs2 = 32'h0;          rdata = 32'h0000_7F00; exp_rdata = 32'h0000_007F; exp_wdata = 32'h0;          exp_wstrb = 4'b0000; end
                4: begin op = MEM_STORE; size = SIZE_BYTE; sgn = 1'b0; addr = 32'h306; rs2 = 32'h1122_33C4; rdata = 32'h0;          exp_rdata = 32'h0;          exp_wdata = 32'hC4C4_C4C4; exp_wstrb = 4'b0100; end
                default: begin op = MEM_STORE; size = SIZE_WORD; sgn = 1'b0; addr = 32'h308; rs2 = 32'hCAFE_F00D; rdata = 32'h0; exp_rdata = 32'h0;       exp_wdata = 32'hCAFE_F00D; exp_wstrb = 4'b1111; end
            endcase
            @(posedge clk); #1;
            drive_instr(op, size, sgn, addr, rs2, 5'(10 + i));
            dmem_req_ready = 1'b1;
            dmem_rsp_rdata = rdata;
            sb.push_back('{alu: addr, rdata: exp_rdata, rd: 5'(10 + i)});
            @(negedge clk);
            n_cmp++;
            if (dmem_req_valid !== 1'b1 || dmem_req_addr !== {addr[31:2], 2'b00} || dmem_req_wstrb !== exp_wstrb ||
                dmem_req_we !== (op == MEM_STORE) || (op == MEM_STORE && dmem_req_wdata !== exp_wdata) || m_ready !== 1'b0) begin
                n_err++; $display("FAIL fmt_req[%0d]: got v%b a%h d%h s%b we%b rdy%b want v1 a%h d%h s%b rdy0", i, dmem_req_valid,
                                  dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, dmem_req_we, m_ready,
                                  {addr[31:2], 2'b00}, exp_wdata, exp_wstrb);
            end
            @(posedge clk); #1;
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b1;
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b0;
            e_to_m = '0;
            @(negedge clk);
            n_cmp++;
            if (m_to_w.valid !== 1'b1 || sb.size() == 0) begin
                n_err++; $display("FAIL fmt_wb_valid[%0d]: got %b want 1", i, m_to_w.valid);
            end else begin
                e = sb.pop_front();
                if (m_to_w.memory_rdata !== e.rdata || m_to_w.alu_result !== e.alu || m_to_w.rd_idx !== e.rd) begin
                    n_err++; $display("FAIL fmt_wb_data[%0d]: got %h/%h/%0d want %h/%h/%0d", i, m_to_w.memory_rdata,
                                      m_to_w.alu_result, m_to_w.rd_idx, e.rdata, e.alu, e.rd);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  size;
        logic [31:0] addr;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin size = SIZE_WORD; addr = 32'h0000_0101; end
                1:       begin size = SIZE_HALF; addr = 32'h0000_0103; end
                default: begin size = 2'b11;     addr = 32'h0000_0100; end
            endcase
            @(posedge clk); #1;
            drive_instr(MEM_LOAD, size, 1'b0, addr, 32'h0, 5'd3);
            dmem_req_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (m_misaligned !== 1'b1 || dmem_req_valid !== 1'b0 || m_ready !== 1'b1) begin
                n_err++; $display("FAIL misaligned[%0d]: got mis%b v%b rdy%b want mis1 v0 rdy1", i, m_misaligned, dmem_req_valid, m_ready);
            end
            @(posedge clk); #1;
            e_to_m = '0;
            dmem_req_ready = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (m_to_w.valid !== 1'b0 || m_misaligned !== 1'b0) begin
                n_err++; $display("FAIL misaligned_after[%0d]: got wbv%b mis%b want 0 0", i, m_to_w.valid, m_misaligned);
            end
        end
    endtask

    task automatic test_flush();
        // Flush in IDLE: no request even though the op is a valid aligned load.
        @(posedge clk); #1;
        drive_instr(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_0500, 32'h0, 5'd9);
        dmem_req_ready = 1'b1;
        m_flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (dmem_req_valid !== 1'b0 || m_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle: got v%b rdy%b want v0 rdy1", dmem_req_valid, m_ready); end
        @(posedge clk); #1;
        m_flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_to_w.valid !== 1'b0) begin n_err++; $display("FAIL flush_idle_wb: got %b want 0", m_to_w.valid); end
        // Accepted here; the flush arrives while waiting for the response.
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        m_flush = 1'b1;
        dmem_rsp_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        m_flush = 1'b0;
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL flush_rsp_ready: got %b want 1", m_ready); end
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        drive_instr(MEM_NOP, SIZE_WORD, 1'b0, 32'h0000_0777, 32'h0, 5'd11);
        sb.push_back('{alu: 32'h0000_0777, rdata: 32'h0, rd: 5'd11});
        @(negedge clk);
        n_cmp++; if (m_to_w.valid !== 1'b0) begin n_err++; $display("FAIL flush_rsp_discard: got %b want 0", m_to_w.valid); end
        @(posedge clk); #1;
        e_to_m = '0;
        @(negedge clk);
        n_cmp++;
        if (m_to_w.valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL flush_next_valid: got %b want 1", m_to_w.valid);
        end else begin
            e = sb.pop_front();
            if (m_to_w.alu_result !== e.alu || m_to_w.rd_idx !== e.rd) begin
                n_err++; $display("FAIL flush_next_data: got %h/%0d want %h/%0d", m_to_w.alu_result, m_to_w.rd_idx, e.alu, e.rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        drive_instr(MEM_LOAD, SIZE_WORD, 1'b0, 32'h0000_0400, 32'h0, 5'd12);
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_waiting: got %b want 0", m_ready); end
        #1;
        rst_n = 1'b0;
        dmem_req_ready = 1'b1;
        #1;
        n_cmp++;
        if (m_to_w.valid !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got wbv%b v%b want 0 0", m_to_w.valid, dmem_req_valid);
        end
        @(posedge clk); #1;
        e_to_m = '0;
        dmem_req_ready = 1'b0;
        rst_n = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h5555_5555;
        @(negedge clk);
        n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_idle: got %b want 1", m_ready); end
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_to_w.valid !== 1'b0) begin n_err++; $display("FAIL stray_rsp_ignored: got %b want 0", m_to_w.valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        e_to_m = '0;
        test_reset();
        test_alu();
        test_lb();
        test_sh_backpressure();
        test_formats();
        test_misaligned();
        test_flush();
        test_reset_mid();
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
